// File: rtl/maxpool2x2_unit.sv
// maxpool2x2_unit
// 2x2, stride-2 max pooling (optional ReLU) over a channel-major feature map
// held in a synchronous RAM with 1-cycle read latency. One tap is read per
// cycle, so every pooled output costs 4 cycles, and the write of window k
// overlaps the reads of window k+1.
//
// Ports:
//   clk      in   clock, all state changes on the rising edge
//   reset    in   synchronous, active-high
//   start    in   one-cycle run request, honoured only in IDLE
//   busy     out  high while taps are being read or the last write is pending
//   done     out  one-cycle completion pulse
//   rd_en    out  input RAM read strobe
//   rd_addr  out  input RAM address (0 whenever rd_en is low)
//   rd_data  in   signed sample, valid one cycle after rd_en
//   wr_en    out  output RAM write strobe
//   wr_addr  out  output RAM address, 0..N_out-1 in window order
//   wr_data  out  signed pooled value
module maxpool2x2_unit #(
  parameter int DATA_W    = 16,
  parameter int IN_W      = 24,
  parameter int IN_H      = 24,
  parameter int CHANNELS  = 6,
  parameter int RELU      = 0,
  parameter int RD_ADDR_W = $clog2(CHANNELS * IN_H * IN_W),
  parameter int WR_ADDR_W = $clog2(CHANNELS * IN_H * IN_W / 4)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_en,
  output logic [RD_ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0]    rd_data,
  output logic                 wr_en,
  output logic [WR_ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0]    wr_data
);

  localparam int OUT_W = IN_W / 2;
  localparam int N_OUT = CHANNELS * (IN_H / 2) * OUT_W;
  localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  generate
    if ((IN_W % 2) != 0 || (IN_H % 2) != 0) begin : g_bad_dims
      $error("maxpool2x2_unit: IN_W and IN_H must both be even");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_next;

  // Read side: tap within the window, output column, window base address and
  // window index (for last-tap detection).
  logic [1:0]           tap;
  logic [COL_W-1:0]     col;
  logic [RD_ADDR_W-1:0] base;
  logic [WR_ADDR_W-1:0] win;
  logic                 last_tap;

  // Data side: read-return tracking, running max and write counter.
  logic                     rd_valid;
  logic [1:0]               tap_q;
  logic [WR_ADDR_W-1:0]     wr_cnt;
  logic signed [DATA_W-1:0] rd_sample;
  logic signed [DATA_W-1:0] max_q;
  logic signed [DATA_W-1:0] max_next;
  logic signed [DATA_W-1:0] pooled;
  logic                     window_end;

  assign last_tap   = (tap == 2'd3) && (win == WR_ADDR_W'(N_OUT - 1));
  assign rd_sample  = $signed(rd_data);
  assign window_end = rd_valid && (tap_q == 2'd3);

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    unique case (state)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN: begin
        busy  = 1'b1;
        rd_en = 1'b1;
        unique case (tap)
          2'd0: rd_addr = base;
          2'd1: rd_addr = base + RD_ADDR_W'(1);
          2'd2: rd_addr = base + RD_ADDR_W'(IN_W);
          2'd3: rd_addr = base + RD_ADDR_W'(IN_W + 1);
          default: rd_addr = base;
        endcase
        if (last_tap) state_next = S_DRAIN;
      end
      // Only the final window's write can occur while draining.
      S_DRAIN: begin
        busy = 1'b1;
        if (wr_en) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Tap 0 data restarts the max; taps 1-3 fold in with a signed compare.
  always_comb begin
    max_next = max_q;
    if (tap_q == 2'd0 || rd_sample > max_q) max_next = rd_sample;
    pooled = max_next;
    if (RELU != 0 && max_next < 0) pooled = '0;
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      tap      <= '0;
      col      <= '0;
      base     <= '0;
      win      <= '0;
      rd_valid <= 1'b0;
      tap_q    <= '0;
      wr_cnt   <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      state    <= state_next;
      rd_valid <= (state == S_RUN);
      tap_q    <= tap;
      wr_en    <= window_end;

      if (state == S_IDLE) begin
        tap    <= '0;
        col    <= '0;
        base   <= '0;
        win    <= '0;
        wr_cnt <= '0;
      end else if (state == S_RUN) begin
        tap <= tap + 2'd1;
        if (tap == 2'd3) begin
          win <= win + WR_ADDR_W'(1);
          // Past the last column, skipping the odd input row lands exactly on
          // the next output row, or on the next channel after the last row.
          if (col == COL_W'(OUT_W - 1)) begin
            col  <= '0;
            base <= base + RD_ADDR_W'(IN_W + 2);
          end else begin
            col  <= col + COL_W'(1);
            base <= base + RD_ADDR_W'(2);
          end
        end
      end

      if (window_end) begin
        wr_addr <= wr_cnt;
        wr_data <= pooled;
        wr_cnt  <= wr_cnt + WR_ADDR_W'(1);
      end
    end
  end

  // NOTE: max_q is left out of reset: it is reloaded by every tap-0 sample
  // before it is ever used, and reset already blocks any partial write.
  always_ff @(posedge clk) begin
    if (rd_valid) max_q <= max_next;
  end

endmodule

// File: doc/maxpool2x2_unit.md
# maxpool2x2_unit

Layer engine that performs 2×2, stride-2 max pooling (with optional ReLU) over a channel-major feature map held in a synchronous RAM. It sits directly downstream of the convolution stage. It reads the conv output RAM and writes the pooled map into the pooling RAM that feeds the next convolution or the fully-connected stage. The layer controller starts it with a one-cycle `start` and waits for the one-cycle `done` pulse.

## Interface
- `DATA_W`, 16: signed sample width.
- `IN_W`, 24: input map width; must be even.
- `IN_H`, 24: input map height; must be even.
- `CHANNELS`, 6: number of feature maps.
- `RELU`, 0: 1 clamps each output to ≥ 0.
- Derived widths:
  - `RD_ADDR_W` = $clog2(CHANNELS·IN_H·IN_W).
  - `WR_ADDR_W` = $clog2(CHANNELS·IN_H·IN_W/4).
  - Odd `IN_W` or `IN_H` is an elaboration error.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle completion pulse.
- `rd_en`  out  1  read strobe to the input RAM.
- `rd_addr`  out  `RD_ADDR_W`  input RAM address.
- `rd_data`  in  `DATA_W`  signed; valid exactly 1 cycle after the matching `rd_en`.
- `wr_en`  out  1  write strobe to the output RAM.
- `wr_addr`  out  `WR_ADDR_W`  output RAM address.
- `wr_data`  out  `DATA_W`  signed pooled value.

## Operation
- **FSM states:** IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DRAIN after the last tap is issued.
  - DRAIN → DONE after the last write.
  - DONE → IDLE unconditionally. `done` is high for this one cycle.
- **Window order:** channel ch (outer), output row r, output column c (inner). N_out = CHANNELS·(IN_H/2)·(IN_W/2).
- **Taps per window, in this order:** base, base+1, base+IN_W, base+IN_W+1.
  - base = ch·IN_H·IN_W + 2r·IN_W + 2c.
  - Exactly one tap is issued per RUN cycle, with `rd_en`=1. Windows follow back-to-back with no bubbles.
- **Accumulation:** a register of `DATA_W` bits.
  - On tap 0 data it loads `rd_data`.
  - On taps 1–3 data it becomes the signed max of the register and `rd_data`.
  - If RELU=1, the final value is max(result, 0).
- **Write:** one registered write per window.
  - wr_addr = ch·(IN_H/2)·(IN_W/2) + r·(IN_W/2) + c, i.e. 0..N_out−1 in order.
- No arithmetic widening. Comparison is two's-complement signed.
- **`start` handling:**
  - `start` while busy is ignored.
  - `start` in the DONE cycle is ignored.
  - A new `start` is accepted in the IDLE cycle after DONE.
- **Reset (at any time, including mid-run):**
  - Next state is IDLE and the window counters clear.
  - Every output is 0: `busy`, `done`, `rd_en`, `rd_addr`, `wr_en`, `wr_addr`, `wr_data`.
  - No partial-window write is emitted afterward.
- Outside RUN, `rd_en`=0 and `rd_addr` holds 0. Outside write cycles, `wr_en`=0, and `wr_addr`/`wr_data` hold their last values.

## Timing
- Let S be the cycle in which `start` is sampled high in IDLE.
- **Reads:** window k, tap j is issued at cycle S+1+4k+j. Its data returns at S+2+4k+j.
- **Max update:** the max register holds window k's full max at the end of cycle S+4k+5.
- **Writes:** `wr_en` is high in cycle S+4k+6 with window k's address and data.
  - Writes therefore recur every 4 cycles.
  - The write for window k overlaps the reads of window k+1.
- **Last window (N_out−1):**
  - last tap issued at S+4·N_out;
  - last write at S+4·N_out+2;
  - `done` at S+4·N_out+3.
- **`busy`:** high from S+1 through S+4·N_out+2 inclusive; low in the `done` cycle.
- **Throughput:** 4 cycles per output. Fixed latency 4·N_out+3 from `start` to `done`.

## Test plan
Directed scenarios use IN_W=4, IN_H=4, CHANNELS=2 (N_out=8). The RAM model returns mem[addr] 1 cycle after `rd_en`.

1. **Basic pooling.**
   - Stimulus: mem[a]=a for a=0..15; mem[a]=−a for a=16..31; RELU=0; pulse `start` at S.
   - Required response:
     - writes (addr:data) 0:5, 1:7, 2:13, 3:15, 4:−16, 5:−18, 6:−24, 7:−26;
     - `done` at S+35 only;
     - `busy` high S+1..S+34.
2. **ReLU.**
   - Stimulus: same data, RELU=1.
   - Required response: addresses 0–3 give 5, 7, 13, 15; addresses 4–7 give 0.
3. **Read sequence.**
   - Stimulus: same data.
   - Required response:
     - `rd_addr` in cycles S+1..S+8 is 0, 1, 4, 5, 2, 3, 6, 7;
     - 32 reads in total;
     - `rd_en` low outside S+1..S+32.
4. **Signed extremes and tap position.**
   - Stimulus: window 0 = {−32768, 32767, −1, 0}; then window 0 = {−5, −3, −9, −7}.
   - Required response: first run writes 32767 at addr 0; second run writes −3, proving a max in tap 1 is not lost.
5. **Reset mid-run.**
   - Stimulus: assert `reset` for 1 cycle at S+10.
   - Required response:
     - in the following cycle all outputs are 0;
     - no `wr_en` occurs afterward;
     - no `done` is produced;
     - a fresh `start` then completes scenario 1 exactly.
6. **Start filtering.**
   - Stimulus: `start` held high continuously from S.
   - Required response:
     - `start` is ignored while busy and in the DONE cycle;
     - exactly one run per accept, the next beginning with the IDLE cycle at S+36;
     - the second run's `done` falls at S+71.
